or_gate_tester: RTL
===================

# or_gate_tester

Self-checking stimulus and response stage wrapped around a 2-input OR gate.
- On a start request it drives the gate's A/B inputs through all four input combinations, holding each for a programmable number of clock cycles.
- It samples the gate's C output at the end of each hold window, compares it to the expected A|B, and counts mismatches.
- It sits directly upstream (A/B) and downstream (C) of the gate, replacing the hand-written delay-based stimulus with a clocked, synthesizable sequencer.

## Interface
Parameters:
- HOLD_CYCLES, 15, clock cycles each input vector is held; legal range >= 1
- ERR_W, 3, width of the mismatch counter; legal range >= 3

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  run request; sampled only in IDLE
- A  output  1  gate input A, registered
- B  output  1  gate input B, registered
- C  input  1  gate output, combinational from A/B
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  1 if the last completed run had zero mismatches
- err_count  output  ERR_W  mismatches in the current or last run, saturating
- vec_idx  output  2  index of the vector currently driven; A=vec_idx[1], B=vec_idx[0]

## Operation
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, state IDLE, hold counter 0.
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - A/B are held at 0.
  - When start=1, clear err_count, set vec_idx=0, set the hold counter to 0, assert busy, and go to DRIVE.
  - pass and err_count keep their last-run values until the next start.
- DRIVE:
  - A/B follow vec_idx.
  - The hold counter increments each cycle.
  - When the counter equals HOLD_CYCLES-1:
    - Compare C with (A|B).
    - On mismatch, increment err_count, saturating at all-ones.
    - Reset the counter to 0.
  - After that compare, if vec_idx < 3, increment vec_idx and stay in DRIVE.
  - If vec_idx = 3, go to FINISH.
- FINISH:
  - Lasts one cycle.
  - done=1, busy=0, pass=(err_count==0), A/B return to 0, vec_idx returns to 0.
  - Next state is IDLE.
- start is ignored while in DRIVE or FINISH.
  - If start is held high through FINISH, a new run begins on the first IDLE cycle.
- A mismatch on vector 3 must be included in the pass computed in FINISH. The mismatch detection is combinational into pass.

## Timing
- Start edge E0 (start=1 in IDLE): the first DRIVE cycle starts after E0, with A/B = 00 and busy=1.
- Vector k is driven for cycles k*HOLD_CYCLES+1 .. (k+1)*HOLD_CYCLES after E0.
- C is sampled in the last cycle of each window.
- done is high in cycle 4*HOLD_CYCLES+1 after E0, and low in every other cycle.
- Run length is 4*HOLD_CYCLES+1 cycles from start to done, plus 1 cycle back to IDLE.
- HOLD_CYCLES=1: a new vector every cycle, with the compare in the same cycle it is driven.
- rst wins over every other event in any state. At the next edge all outputs take their reset values, and the run is abandoned with no done pulse.

## Configuration
- OR_GATE_TESTER_FAIL_LOG_EN defined:
  - Adds output ports first_fail_idx (2 bits) and fail_seen (1 bit).
  - On the first mismatch of a run, capture vec_idx into first_fail_idx and set fail_seen=1.
  - Later mismatches do not overwrite the capture.
  - Both ports are cleared on start and on rst.
- OR_GATE_TESTER_FAIL_LOG_EN undefined:
  - The ports and their logic are absent.
  - All other behaviour is identical.

## Test plan
- Correct gate (C=A|B), HOLD_CYCLES=15, start pulsed → busy for 60 cycles, A/B sequence 00,01,10,11, done pulse at cycle 61, pass=1, err_count=0.
- C stuck at 0 → err_count=3, pass=0. With FAIL_LOG_EN: first_fail_idx=1, fail_seen=1.
- C stuck at 1 → err_count=1, pass=0. With FAIL_LOG_EN: first_fail_idx=0.
- Mid-run behaviour:
  - Pulse start again during vector 1 → ignored, the run completes normally.
  - Assert rst during vector 2 → next edge: busy=0, A=B=0, err_count=0, and no done pulse ever occurs for that run.
- HOLD_CYCLES=1 with the correct gate and start held high → done every 6th cycle (4 DRIVE, 1 FINISH, 1 IDLE), pass=1 each run.
- ERR_W=3 with C inverted (C=~(A|B)) and start held across two runs → err_count=4 per run. The second run restarts from 0, not 8.

Source files
------------

// File: rtl/or_gate_tester.sv
// or_gate_tester: clocked stimulus/response sequencer that drives all four A/B vectors into an OR gate and checks C.
// Optional first-failure capture ports are enabled with OR_GATE_TESTER_FAIL_LOG_EN.
module or_gate_tester #(
  parameter int HOLD_CYCLES = 15,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef OR_GATE_TESTER_FAIL_LOG_EN
  ,
  output logic [1:0]       first_fail_idx,
  output logic             fail_seen
`endif
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic w_start, w_last, w_mis;
  logic [ERR_W-1:0] w_err;
  logic [1:0] w_vec_inc;
  always_comb begin
    w_start   = (r_state == IDLE) && start;
    w_last    = (r_state == DRIVE) && (r_cnt == CW'(HOLD_CYCLES - 1));
    w_mis     = w_last && (C != (A | B));
    w_err     = (w_mis && !(&err_count)) ? err_count + 1'b1 : err_count;
    w_vec_inc = vec_idx + 2'd1;
    w_next    = r_state == IDLE  ? (start ? DRIVE : IDLE) :
                r_state == DRIVE ? ((w_last && vec_idx == 2'd3) ? FINISH : DRIVE) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // Outputs are registered; the final-vector mismatch feeds pass through w_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_idx   <= 2'd0;
      r_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (w_start) begin
        err_count <= '0;
        vec_idx   <= 2'd0;
        r_cnt     <= '0;
        busy      <= 1'b1;
        A         <= 1'b0;
        B         <= 1'b0;
      end else if (r_state == DRIVE) begin
        err_count <= w_err;
        r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last && vec_idx == 2'd3) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (w_err == '0);
          vec_idx <= 2'd0;
          A       <= 1'b0;
          B       <= 1'b0;
        end else if (w_last) begin
          vec_idx <= w_vec_inc;
          A       <= w_vec_inc[1];
          B       <= w_vec_inc[0];
        end
      end
    end
  end
`ifdef OR_GATE_TESTER_FAIL_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      first_fail_idx <= 2'd0;
      fail_seen      <= 1'b0;
    end else if (w_mis && !fail_seen) begin
      first_fail_idx <= vec_idx;
      fail_seen      <= 1'b1;
    end
  end
`endif
endmodule
